// File: rtl/issue_ctrl_if.sv
// issue_ctrl_if: decode-stage issue bundle between the pipeline and issue_ctrl.
//   master : pipeline side, drives the IF/ID fields, EX redirect and load writeback;
//            receives the issue decision.
//   slave  : issue_ctrl side.
// Signals: id_valid, opcode[6:0], rd/rs1/rs2[4:0], ex_branch_taken, ld_done, ld_rd[4:0]
//          (pipeline -> controller); id_issue, id_stall, id_ex_bubble, if_id_flush,
//          ld_err (controller -> pipeline).
interface issue_ctrl_if;
  localparam int unsigned OP_W  = 7;
  localparam int unsigned REG_W = 5;

  logic             id_valid;
  logic [OP_W-1:0]  opcode;
  logic [REG_W-1:0] rd;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic             ex_branch_taken;
  logic             ld_done;
  logic [REG_W-1:0] ld_rd;
  logic             id_issue;
  logic             id_stall;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             ld_err;

  modport master (
    output id_valid, opcode, rd, rs1, rs2, ex_branch_taken, ld_done, ld_rd,
    input  id_issue, id_stall, id_ex_bubble, if_id_flush, ld_err
  );

  modport slave (
    input  id_valid, opcode, rd, rs1, rs2, ex_branch_taken, ld_done, ld_rd,
    output id_issue, id_stall, id_ex_bubble, if_id_flush, ld_err
  );
endinterface

// File: rtl/issue_ctrl.sv
// issue_ctrl: decode-stage issue controller. Tracks destination registers of
// outstanding loads in a scoreboard, interlocks RAW/WAW hazards and the
// outstanding-load limit, drains all loads before a FENCE issues, and flushes
// IF/ID on a taken branch resolved in EX.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : issue_ctrl_if.slave (instruction fields, redirect, load
//                writeback in; issue/stall/bubble/flush decisions and sticky
//                ld_err out)
// Parameter: MAX_LD (1..7) maximum number of outstanding loads.
// Build option: define ISSUE_CTRL_LD_BYPASS_EN to let a load completing this
// cycle release its dependents and its counter slot in the same cycle.
// id_issue/id_stall/id_ex_bubble/if_id_flush are combinational decisions;
// ld_err comes straight from a flop.
module issue_ctrl #(
  parameter int unsigned MAX_LD = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  issue_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned NREG   = 32;
  localparam int unsigned OP_W   = 7;

  localparam logic [OP_W-1:0] OP_OP     = 7'b0110011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_FENCE  = 7'b0001111;

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic              ld_err_q, ld_err_d;

  logic              use_rs1_c, use_rs2_c, wr_rd_c;
  logic              ld_ok_c;
  logic [NREG-1:0]   busy_chk_c;
  logic [CNT_W-1:0]  cnt_chk_c;
  logic              hazard_c;
  logic              is_load_c, is_fence_c;
  logic              issue_c, stall_c, bubble_c, flush_c;

  // Register usage by opcode; unlisted opcodes read and write nothing.
  always_comb begin
    use_rs1_c = 1'b0;
    use_rs2_c = 1'b0;
    wr_rd_c   = 1'b0;
    unique case (bus.opcode)
      OP_OP:     begin use_rs1_c = 1'b1; use_rs2_c = 1'b1; wr_rd_c = 1'b1; end
      OP_STORE,
      OP_BRANCH: begin use_rs1_c = 1'b1; use_rs2_c = 1'b1; end
      OP_IMM,
      OP_LOAD,
      OP_JALR:   begin use_rs1_c = 1'b1; wr_rd_c = 1'b1; end
      OP_LUI,
      OP_AUIPC,
      OP_JAL:    wr_rd_c = 1'b1;
      default:   ;
    endcase
  end

  assign is_load_c  = (bus.opcode == OP_LOAD);
  assign is_fence_c = (bus.opcode == OP_FENCE);

  // A completion is legal only with a load outstanding and, for a real
  // register, only if that register is marked busy.
  assign ld_ok_c = bus.ld_done && (ld_cnt_q != '0) &&
                   ((bus.ld_rd == '0) || busy_q[bus.ld_rd]);

  // View of the scoreboard and counter used for hazard detection.
  always_comb begin
    busy_chk_c = busy_q;
    cnt_chk_c  = ld_cnt_q;
`ifdef ISSUE_CTRL_LD_BYPASS_EN
    if (ld_ok_c) begin
      busy_chk_c[bus.ld_rd] = 1'b0;
      cnt_chk_c             = ld_cnt_q - CNT_W'(1);
    end
`endif
  end

  assign hazard_c = bus.id_valid && (
                      (use_rs1_c && (bus.rs1 != '0) && busy_chk_c[bus.rs1]) ||
                      (use_rs2_c && (bus.rs2 != '0) && busy_chk_c[bus.rs2]) ||
                      (wr_rd_c   && (bus.rd  != '0) && busy_chk_c[bus.rd])  ||
                      (is_load_c && (cnt_chk_c == CNT_W'(MAX_LD))));

  // Issue FSM: branch redirect beats stalls, stalls beat issue.
  always_comb begin
    state_d  = state_q;
    issue_c  = 1'b0;
    stall_c  = 1'b0;
    bubble_c = 1'b1;
    flush_c  = 1'b0;
    if (bus.ex_branch_taken) begin
      flush_c = 1'b1;
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (hazard_c) begin
            stall_c = 1'b1;
          end else if (bus.id_valid && is_fence_c && (ld_cnt_q != '0)) begin
            stall_c = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            issue_c  = bus.id_valid;
            bubble_c = !bus.id_valid;
          end
        end
        ST_DRAIN: begin
          if (ld_cnt_q == '0) begin
            issue_c  = bus.id_valid;
            bubble_c = !bus.id_valid;
            state_d  = ST_RUN;
          end else begin
            stall_c = 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Scoreboard/counter update; a same-cycle set of busy[rd] wins over a clear.
  always_comb begin
    busy_d   = busy_q;
    ld_cnt_d = ld_cnt_q;
    ld_err_d = ld_err_q;
    if (bus.ld_done) begin
      if (ld_ok_c) begin
        busy_d[bus.ld_rd] = 1'b0;
        ld_cnt_d          = ld_cnt_d - CNT_W'(1);
      end else begin
        ld_err_d = 1'b1;
      end
    end
    if (issue_c && is_load_c) begin
      ld_cnt_d = ld_cnt_d + CNT_W'(1);
      if (bus.rd != '0) begin
        busy_d[bus.rd] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      busy_q   <= '0;
      ld_cnt_q <= '0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      ld_cnt_q <= ld_cnt_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign bus.id_issue     = issue_c;
  assign bus.id_stall     = stall_c;
  assign bus.id_ex_bubble = bubble_c;
  assign bus.if_id_flush  = flush_c;
  assign bus.ld_err       = ld_err_q;

endmodule
